// File: rtl/l1mtx_pkg.sv
// Shared AHB encodings and input-stage FSM encoding for the L1 matrix
// (input stage and arbiter).
package l1mtx_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [0:0] ST_LIVE = 1'b0;
  localparam logic [0:0] ST_HELD = 1'b1;

  // Address-phase control fields (address kept separate: its width is per-instance)
  typedef struct packed {
    logic       sel;
    logic [1:0] trans;
    logic       write;
    logic [2:0] size;
    logic [2:0] burst;
    logic [3:0] prot;
    logic       lock;
  } ahb_ctrl_t;

endpackage

// File: rtl/l1mtx_input_stage.sv
// Matrix input stage: passes a master's address phase straight through, or
// parks it in a holding register until the output stage grants it.
module l1mtx_input_stage
  import l1mtx_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSELS,
  input  logic [ADDR_W-1:0] HADDRS,
  input  logic [1:0]        HTRANSS,
  input  logic              HWRITES,
  input  logic [2:0]        HSIZES,
  input  logic [2:0]        HBURSTS,
  input  logic [3:0]        HPROTS,
  input  logic              HMASTLOCKS,
  input  logic              HREADYS,
  input  logic              addr_accepted,
  input  logic              resp_err,
  output logic              HSELM,
  output logic [ADDR_W-1:0] HADDRM,
  output logic [1:0]        HTRANSM,
  output logic              HWRITEM,
  output logic [2:0]        HSIZEM,
  output logic [2:0]        HBURSTM,
  output logic [3:0]        HPROTM,
  output logic              HMASTLOCKM,
  output logic              trans_req,
  output logic              held_tran
);

  logic [0:0]        state_q, state_d;
  ahb_ctrl_t         ctrl_q, ctrl_live, ctrl_m;
  logic [ADDR_W-1:0] addr_q;
  logic              live_valid;
  logic              hold_load;

  assign live_valid = HSELS & HTRANSS[1] & HREADYS;
  assign held_tran  = (state_q == ST_HELD);
  assign hold_load  = (state_q == ST_LIVE) & HREADYS;

  assign ctrl_live = '{sel: HSELS, trans: HTRANSS, write: HWRITES, size: HSIZES,
                       burst: HBURSTS, prot: HPROTS, lock: HMASTLOCKS};

  always_comb begin
    state_d = state_q;
    if (state_q == ST_LIVE) begin
      if (live_valid & ~addr_accepted) state_d = ST_HELD;
    end else begin
      // An error response wins over a same-cycle grant: the transfer is dropped.
      if (resp_err | addr_accepted) state_d = ST_LIVE;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= ST_LIVE;
    else          state_q <= state_d;
  end

  // Captures every completed address phase while live, so the one that
  // missed its grant is already here when the FSM enters ST_HELD.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ctrl_q <= '0;
      addr_q <= '0;
    end else if (hold_load) begin
      ctrl_q <= ctrl_live;
      addr_q <= HADDRS;
    end
  end

  always_comb begin
    ctrl_m = held_tran ? ctrl_q : ctrl_live;
    // A held SEQ of an undefined-length burst restarts as NONSEQ at the slave.
    if (held_tran && ctrl_q.trans == HTRANS_SEQ && ctrl_q.burst == HBURST_INCR)
      ctrl_m.trans = HTRANS_NONSEQ;
    if (resp_err) ctrl_m.trans = HTRANS_IDLE;
  end

  assign HSELM      = ctrl_m.sel;
  assign HADDRM     = held_tran ? addr_q : HADDRS;
  assign HTRANSM    = ctrl_m.trans;
  assign HWRITEM    = ctrl_m.write;
  assign HSIZEM     = ctrl_m.size;
  assign HBURSTM    = ctrl_m.burst;
  assign HPROTM     = ctrl_m.prot;
  assign HMASTLOCKM = ctrl_m.lock;
  assign trans_req  = ~resp_err & (held_tran | live_valid);

endmodule

// File: tb/tb_l1mtx_input_stage.sv
// Directed bench for l1mtx_input_stage: pass-through, hold/grant, SEQ INCR
// rewrite, error discard, reset mid-hold and non-transfer cases.
module tb_l1mtx_input_stage;
  import l1mtx_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSELS, HWRITES, HMASTLOCKS, HREADYS, addr_accepted, resp_err;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic [2:0]  HSIZES, HBURSTS;
  logic [3:0]  HPROTS;
  logic        HSELM, HWRITEM, HMASTLOCKM, trans_req, held_tran;
  logic [31:0] HADDRM;
  logic [1:0]  HTRANSM;
  logic [2:0]  HSIZEM, HBURSTM;
  logic [3:0]  HPROTM;

  int checks = 0;
  int failures = 0;

  l1mtx_input_stage #(.ADDR_W(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS), .HWRITES(HWRITES),
    .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS),
    .HREADYS(HREADYS), .addr_accepted(addr_accepted), .resp_err(resp_err),
    .HSELM(HSELM), .HADDRM(HADDRM), .HTRANSM(HTRANSM), .HWRITEM(HWRITEM),
    .HSIZEM(HSIZEM), .HBURSTM(HBURSTM), .HPROTM(HPROTM), .HMASTLOCKM(HMASTLOCKM),
    .trans_req(trans_req), .held_tran(held_tran)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input logic sel, input logic [31:0] addr, input logic [1:0] tr,
                       input logic wr, input logic [2:0] sz, input logic [2:0] bu,
                       input logic lk, input logic rdy, input logic acc, input logic err);
    HSELS = sel; HADDRS = addr; HTRANSS = tr; HWRITES = wr; HSIZES = sz;
    HBURSTS = bu; HPROTS = 4'h3; HMASTLOCKS = lk; HREADYS = rdy;
    addr_accepted = acc; resp_err = err;
    #1;
  endtask

  // Master-side inputs while a transfer is held: HREADYS low, garbage on the bus
  task automatic drive_stall(input logic acc, input logic err);
    drive(1'b0, 32'hDEAD_BEE0, HTRANS_IDLE, 1'b0, 3'd0, HBURST_SINGLE, 1'b0, 1'b0, acc, err);
  endtask

  task automatic drive_idle();
    drive(1'b0, 32'h0, HTRANS_IDLE, 1'b0, 3'd0, HBURST_SINGLE, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    HRESETn = 1'b0;
    #3;
    // Reset asserted: outputs follow live inputs, no hold despite no grant
    drive(1'b1, 32'h0000_00A0, HTRANS_NONSEQ, 1'b0, 3'd2, HBURST_SINGLE, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("rst_held", held_tran, 1'b0);
    chk("rst_req", trans_req, 1'b1);
    chk("rst_addr", HADDRM, 32'hA0);
    tick();
    chk("rst_held_edge", held_tran, 1'b0);
    drive_idle();
    HRESETn = 1'b1;
    tick();

    // Pass-through NONSEQ SINGLE, granted at once
    drive(1'b1, 32'h0000_1000, HTRANS_NONSEQ, 1'b0, 3'd2, HBURST_SINGLE, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("pass_addr", HADDRM, 32'h1000);
    chk("pass_trans", HTRANSM, HTRANS_NONSEQ);
    chk("pass_req", trans_req, 1'b1);
    chk("pass_held", held_tran, 1'b0);
    tick();
    drive_idle();
    chk("pass_held_after", held_tran, 1'b0);
    chk("pass_idle_req", trans_req, 1'b0);
    tick();

    // Held write at 0x2004, granted in the third held cycle
    drive(1'b1, 32'h0000_2004, HTRANS_NONSEQ, 1'b1, 3'd2, HBURST_SINGLE, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("h2_live_held", held_tran, 1'b0);
    chk("h2_live_addr", HADDRM, 32'h2004);
    for (int i = 0; i < 3; i++) begin
      tick();
      drive_stall(i == 2, 1'b0);
      chk($sformatf("h2_held_%0d", i), held_tran, 1'b1);
      chk($sformatf("h2_addr_%0d", i), HADDRM, 32'h2004);
      chk($sformatf("h2_req_%0d", i), trans_req, 1'b1);
    end
    chk("h2_write", HWRITEM, 1'b1);
    chk("h2_size", HSIZEM, 3'd2);
    chk("h2_sel", HSELM, 1'b1);
    chk("h2_prot", HPROTM, 4'h3);
    tick();
    drive_idle();
    chk("h2_released", held_tran, 1'b0);
    chk("h2_released_addr", HADDRM, 32'h0);
    tick();

    // Held SEQ INCR becomes NONSEQ; live cycle still shows SEQ
    drive(1'b1, 32'h0000_3008, HTRANS_SEQ, 1'b0, 3'd2, HBURST_INCR, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("incr_live_trans", HTRANSM, HTRANS_SEQ);
    for (int i = 0; i < 2; i++) begin
      tick();
      drive_stall(i == 1, 1'b0);
      chk($sformatf("incr_held_trans_%0d", i), HTRANSM, HTRANS_NONSEQ);
      chk($sformatf("incr_held_addr_%0d", i), HADDRM, 32'h3008);
    end
    tick();
    drive_idle();
    chk("incr_released", held_tran, 1'b0);
    tick();

    // Held SEQ INCR4 keeps SEQ
    drive(1'b1, 32'h0000_3010, HTRANS_SEQ, 1'b0, 3'd2, HBURST_INCR4, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive_stall(1'b1, 1'b0);
    chk("incr4_held_trans", HTRANSM, HTRANS_SEQ);
    chk("incr4_burst", HBURSTM, HBURST_INCR4);
    tick();
    drive_idle();
    chk("incr4_released", held_tran, 1'b0);
    tick();

    // Error with same-cycle grant while held: forced IDLE, transfer dropped
    drive(1'b1, 32'h0000_4000, HTRANS_NONSEQ, 1'b0, 3'd2, HBURST_SINGLE, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive_stall(1'b1, 1'b1);
    chk("err_held", held_tran, 1'b1);
    chk("err_trans", HTRANSM, HTRANS_IDLE);
    chk("err_req", trans_req, 1'b0);
    tick();
    drive_idle();
    chk("err_live_next", held_tran, 1'b0);
    chk("err_no_req", trans_req, 1'b0);
    tick();

    // Error cycle in ST_LIVE also masks a live transfer
    drive(1'b1, 32'h0000_4100, HTRANS_NONSEQ, 1'b0, 3'd2, HBURST_SINGLE, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("err_live_trans", HTRANSM, HTRANS_IDLE);
    chk("err_live_req", trans_req, 1'b0);
    tick();
    drive_idle();

    // Locked transfer held, then reset mid-hold
    drive(1'b1, 32'h0000_5000, HTRANS_NONSEQ, 1'b1, 3'd1, HBURST_SINGLE, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive_stall(1'b0, 1'b0);
    chk("lock_held", HMASTLOCKM, 1'b1);
    chk("lock_held_addr", HADDRM, 32'h5000);
    #2;
    HRESETn = 1'b0;
    #1;
    chk("rst_mid_held", held_tran, 1'b0);
    chk("rst_mid_lock", HMASTLOCKM, 1'b0);
    chk("rst_mid_addr", HADDRM, 32'hDEAD_BEE0);
    tick();
    HRESETn = 1'b1;
    drive_idle();
    chk("rst_rel_req", trans_req, 1'b0);
    tick();
    chk("rst_rel_held", held_tran, 1'b0);
    chk("rst_rel_req2", trans_req, 1'b0);

    // IDLE / BUSY selected and ungranted never hold
    drive(1'b1, 32'h0000_6000, HTRANS_IDLE, 1'b0, 3'd2, HBURST_SINGLE, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("idle_req", trans_req, 1'b0);
    tick();
    chk("idle_no_hold", held_tran, 1'b0);
    drive(1'b1, 32'h0000_6004, HTRANS_BUSY, 1'b0, 3'd2, HBURST_INCR, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("busy_req", trans_req, 1'b0);
    tick();
    chk("busy_no_hold", held_tran, 1'b0);

    // Live NONSEQ with HREADYS low: no request, passes HTRANS, no hold
    drive(1'b1, 32'h0000_7000, HTRANS_NONSEQ, 1'b0, 3'd2, HBURST_SINGLE, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("nrdy_req", trans_req, 1'b0);
    chk("nrdy_trans", HTRANSM, HTRANS_NONSEQ);
    tick();
    chk("nrdy_no_hold", held_tran, 1'b0);
    drive_idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
